dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Sits between the memory-stage control/ALU outputs and the data memory, and owns the data memory's single port.
- Queues stores in a small FIFO and drains them into data memory in cycles when no load needs the port.
- Loads get priority on the port and are answered in the same cycle, forwarded from the youngest matching pending store when one exists.
- Lets the datapath issue a store without waiting on the memory write.

Parameters:
DEPTH, 4, number of store entries (power of two, >=2)
AW, 32, address width (word address, matches data memory Addr)
DW, 32, data width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
st_valid  in  1  store request this cycle
ld_valid  in  1  load request this cycle
addr  in  AW  load/store word address
wdata  in  DW  store data
ld_data  out  DW  load result, valid when ld_ready=1
ld_ready  out  1  load answered this cycle
stall  out  1  request not accepted; hold inputs stable
sb_empty  out  1  no pending stores
mem_wr  out  1  to data memory Ewr
mem_rd  out  1  to data memory Erd
mem_addr  out  AW  to data memory Addr
mem_wdata  out  DW  to data memory RDir
mem_rdata  in  DW  from data memory MOut (combinational read)

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst).
- Storage: circular FIFO of DEPTH entries {addr, data}.
  - rd_ptr, wr_ptr: log2(DEPTH) bits, wrap modulo DEPTH.
  - count: log2(DEPTH)+1 bits.
- Reset: on the clk edge with rst=1:
  - pointers=0, count=0, all entries invalidated.
  - Outputs in the reset cycle and until the next request: sb_empty=1, stall=0, ld_ready=0, mem_wr=0, mem_rd=0, ld_data=0.
  - Reset mid-drain discards every pending store. Software owns draining before reset.
- Port arbitration (combinational, each cycle):
  - ld_valid=1 and load not stalled: mem_rd=1, mem_addr=addr, mem_wr=0.
  - Otherwise, count>0: drain the head. mem_wr=1, mem_addr=head.addr, mem_wdata=head.data, rd_ptr++ on the edge.
  - Otherwise: mem_wr=0, mem_rd=0.
- Load, zero latency:
  - ld_ready=1 in the same cycle.
  - ld_data = data of the youngest valid entry with entry.addr==addr (full AW compare), else mem_rdata.
  - The store enqueued in the same cycle is not visible to that load.
- Store acceptance:
  - Accepted when count<DEPTH, or count==DEPTH and a drain happens this cycle.
  - On acceptance: entry[wr_ptr]={addr,wdata}, wr_ptr++.
  - Not accepted: stall=1, nothing written.
- count update: +1 on enqueue only, -1 on drain only, unchanged on both or neither.
- Simultaneous st_valid and ld_valid (same addr):
  - Load is served first, from prior entries.
  - Store is accepted if space exists.
  - Drain is blocked that cycle.
- Full plus continuous loads: the buffer cannot drain, so stall stays high until a load-free cycle.
- sb_empty = (count==0).

Optional Feature:
- DMEM_SB_FWD_EN defined:
  - Loads forward as above.
- Not defined:
  - A load whose addr matches any valid entry gets stall=1, ld_ready=0, mem_rd=0.
  - The port is given to draining until no matching entry remains; the load then reads mem_rdata.
  - A non-matching load behaves as normal.

Decomposition:
- Shared package holds:
  - SB_DEPTH, SB_AW, SB_DW defaults.
  - Packed entry typedef {addr, data}.
  - Arbitration-select enum {ARB_IDLE, ARB_LOAD, ARB_DRAIN}.
- One natural sub-module, sb_match: takes the entry array, valid mask, rd_ptr and addr. It returns hit plus the youngest matching data by priority search from wr_ptr-1 back to rd_ptr.

Test Plan:
- Reset, then store addr=5 data=0xAAAA0001 with no loads:
  - Next cycle mem_wr=1, mem_addr=5, mem_wdata=0xAAAA0001.
  - Following cycle sb_empty=1.
- Stores to addr 3 (0x11) then addr 3 (0x22), then load addr 3 with both pending:
  - ld_ready=1, ld_data=0x22, mem_wr=0 that cycle.
  - Without DMEM_SB_FWD_EN: stall=1 until both are drained, then ld_data=0x22 from memory.
- Fill 4 stores while ld_valid is held on addr 9 (miss):
  - 5th store gets stall=1.
  - Drop ld_valid: 5th store accepted in the same cycle as the drain, count stays 4.
- Store 0x55 to addr 7 and load addr 7 in the same cycle, memory holding 0x10:
  - ld_data=0x10; next cycle the store drains.
- Assert rst with 3 pending stores:
  - Next cycle sb_empty=1, mem_wr=0, and no write reaches memory.
- Wrap-around: 10 back-to-back store/drain pairs to addrs 0..9:
  - Memory receives them in order; pointers wrap, no loss.

Source files
------------

// File: rtl/dmem_store_buffer_pkg.sv
// Shared defaults and types for the data-memory store buffer.
package dmem_store_buffer_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_LOAD, ARB_DRAIN} sb_arb_e;
endpackage

// File: rtl/dmem_store_buffer_if.sv
// Datapath request/response and data-memory port bundle for the store buffer.
interface dmem_store_buffer_if #(parameter int AW = 32, parameter int DW = 32);
  logic          st_valid;
  logic          ld_valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          stall;
  logic          sb_empty;
  logic          mem_wr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output st_valid, ld_valid, addr, wdata, mem_rdata,
    input  ld_data, ld_ready, stall, sb_empty, mem_wr, mem_rd, mem_addr, mem_wdata
  );
  modport slave (
    input  st_valid, ld_valid, addr, wdata, mem_rdata,
    output ld_data, ld_ready, stall, sb_empty, mem_wr, mem_rd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_store_buffer_sb_match.sv
// Address match over pending stores; returns the youngest matching entry's data.
module sb_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][AW-1:0] ent_addr,
  input  logic [DEPTH-1:0][DW-1:0] ent_data,
  input  logic [DEPTH-1:0]         ent_vld,
  input  logic [PW-1:0]            rd_ptr,
  input  logic [AW-1:0]            addr,
  output logic                     hit,
  output logic [DW-1:0]            data
);
  logic [PW-1:0] idx;

  // Walk oldest to youngest; later hits overwrite, so the youngest wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (ent_vld[idx] && ent_addr[idx] == addr) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end
endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer owning the data-memory port: loads win the port, stores drain when idle.
// DMEM_SB_FWD_EN: forward load data from pending stores; otherwise matching loads stall.
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input logic                clk,
  input logic                rst,
  dmem_store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;
  logic [DEPTH-1:0]         ent_vld;
  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [CW-1:0]            count;

  logic          ld_req, st_req, ld_blk, ld_go, drain, st_ok, enq, hit;
  logic [DW-1:0] fwd_data;
  sb_arb_e       arb;

  sb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_match (
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .ent_vld  (ent_vld),
    .rd_ptr   (rd_ptr),
    .addr     (sb.addr),
    .hit      (hit),
    .data     (fwd_data)
  );

  // Requests are masked during reset so no port activity leaks out of that cycle.
  always_comb begin
    ld_req = sb.ld_valid & ~rst;
    st_req = sb.st_valid & ~rst;
`ifdef DMEM_SB_FWD_EN
    ld_blk = 1'b0;
`else
    ld_blk = ld_req & hit;
`endif
    ld_go = ld_req & ~ld_blk;
    if (rst)                arb = ARB_IDLE;
    else if (ld_go)         arb = ARB_LOAD;
    else if (count != '0)   arb = ARB_DRAIN;
    else                    arb = ARB_IDLE;
    drain = (arb == ARB_DRAIN);
    st_ok = (count < CW'(DEPTH)) | drain;
    enq   = st_req & st_ok & ~ld_blk;

    sb.stall     = (st_req & ~st_ok) | ld_blk;
    sb.sb_empty  = rst | (count == '0);
    sb.mem_rd    = (arb == ARB_LOAD);
    sb.mem_wr    = drain;
    sb.mem_addr  = '0;
    sb.mem_wdata = '0;
    if (arb == ARB_LOAD) sb.mem_addr = sb.addr;
    if (drain) begin
      sb.mem_addr  = ent_addr[rd_ptr];
      sb.mem_wdata = ent_data[rd_ptr];
    end
    // Without forwarding a served load never hits, so this also covers that build.
    sb.ld_ready = ld_go;
    sb.ld_data  = ld_go ? (hit ? fwd_data : sb.mem_rdata) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      // Clear before set: on a full drain+enqueue rd_ptr==wr_ptr and the new entry must stay valid.
      if (drain) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      if (enq) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      case ({enq, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr] <= sb.addr;
      ent_data[wr_ptr] <= sb.wdata;
    end
  end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed-vector bench for dmem_store_buffer with a 64-word behavioural data memory.
module tb_dmem_store_buffer;
  import dmem_store_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  logic [31:0] mem [64];
  int nvec, nerr;

  always #5 clk = ~clk;

  dmem_store_buffer_if #(.AW(32), .DW(32)) bus ();

  dmem_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 64; i++) mem[i] <= '0;
    else if (bus.mem_wr) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic st, input logic ld, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = st;
    bus.ld_valid = ld;
    bus.addr     = a;
    bus.wdata    = d;
    #2;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    mem_clr = 1'b1;
    drv(0, 0, 0, 0);
    tick(); tick();
    mem_clr = 1'b0;

    // reset cycle: requests present but ignored
    drv(1, 1, 5, 32'h77);
    chk("rst_empty", bus.sb_empty, 1);
    chk("rst_stall", bus.stall, 0);
    chk("rst_ldrdy", bus.ld_ready, 0);
    chk("rst_memwr", bus.mem_wr, 0);
    chk("rst_memrd", bus.mem_rd, 0);
    chk("rst_lddata", bus.ld_data, 0);
    tick();
    rst = 1'b0;
    drv(0, 0, 0, 0);
    chk("post_rst_empty", bus.sb_empty, 1);
    chk("post_rst_memwr", bus.mem_wr, 0);

    // single store, drained next cycle
    drv(1, 0, 5, 32'hAAAA0001);
    chk("t1_stall", bus.stall, 0);
    tick();
    drv(0, 0, 0, 0);
    chk("t1_memwr", bus.mem_wr, 1);
    chk("t1_addr", bus.mem_addr, 5);
    chk("t1_wdata", bus.mem_wdata, 32'hAAAA0001);
    tick();
    chk("t1_empty", bus.sb_empty, 1);
    chk("t1_mem5", mem[5], 32'hAAAA0001);

    // preload mem[3]=DEAD, mem[7]=10 through the buffer
    drv(1, 0, 3, 32'hDEAD); tick();
    drv(1, 0, 7, 32'h10);   tick();
    drv(0, 0, 0, 0);        tick();
    chk("pre_empty", bus.sb_empty, 1);
    chk("pre_mem3", mem[3], 32'hDEAD);

    // two stores to addr 3, then load addr 3
    drv(1, 1, 3, 32'h11);
    chk("t2_c1_rdy", bus.ld_ready, 1);
    chk("t2_c1_data", bus.ld_data, 32'hDEAD);
    chk("t2_c1_memrd", bus.mem_rd, 1);
    chk("t2_c1_memwr", bus.mem_wr, 0);
    tick();
`ifdef DMEM_SB_FWD_EN
    drv(1, 1, 3, 32'h22);
    chk("t2_c2_data", bus.ld_data, 32'h11);
    chk("t2_c2_stall", bus.stall, 0);
    tick();
    drv(0, 1, 3, 0);
    chk("t2_c3_rdy", bus.ld_ready, 1);
    chk("t2_c3_data", bus.ld_data, 32'h22);
    chk("t2_c3_memwr", bus.mem_wr, 0);
    tick();
    drv(0, 0, 0, 0);
    chk("t2_dr1", bus.mem_wdata, 32'h11);
    tick();
    chk("t2_dr2", bus.mem_wdata, 32'h22);
    tick();
`else
    drv(1, 1, 3, 32'h22);
    chk("t2_c2_stall", bus.stall, 1);
    chk("t2_c2_rdy", bus.ld_ready, 0);
    chk("t2_c2_memrd", bus.mem_rd, 0);
    chk("t2_c2_dr", bus.mem_wdata, 32'h11);
    tick();
    chk("t2_c3_stall", bus.stall, 0);
    chk("t2_c3_data", bus.ld_data, 32'h11);
    tick();
    drv(0, 1, 3, 0);
    chk("t2_c4_stall", bus.stall, 1);
    chk("t2_c4_dr", bus.mem_wdata, 32'h22);
    tick();
    chk("t2_c5_rdy", bus.ld_ready, 1);
    chk("t2_c5_data", bus.ld_data, 32'h22);
    tick();
    drv(0, 0, 0, 0);
`endif
    chk("t2_empty", bus.sb_empty, 1);
    chk("t2_mem3", mem[3], 32'h22);

    // fill while loads hold the port, addresses 9..12
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 9 + i, 32'h900 + i);
      chk($sformatf("t3_fill%0d_stall", i), bus.stall, 0);
      chk($sformatf("t3_fill%0d_memwr", i), bus.mem_wr, 0);
      tick();
    end
    drv(1, 1, 13, 32'h904);
    chk("t3_full_stall", bus.stall, 1);
    chk("t3_full_rdy", bus.ld_ready, 1);
    tick();
    chk("t3_full_stall2", bus.stall, 1);
    bus.ld_valid = 1'b0;
    #2;
    chk("t3_acc_stall", bus.stall, 0);
    chk("t3_acc_memwr", bus.mem_wr, 1);
    chk("t3_acc_addr", bus.mem_addr, 9);
    tick();
    drv(0, 0, 0, 0);
    for (int j = 10; j <= 13; j++) begin
      chk($sformatf("t3_dr%0d_memwr", j), bus.mem_wr, 1);
      chk($sformatf("t3_dr%0d_addr", j), bus.mem_addr, j);
      chk($sformatf("t3_dr%0d_data", j), bus.mem_wdata, 32'h900 + j - 9);
      tick();
    end
    chk("t3_empty", bus.sb_empty, 1);

    // same-cycle store+load on addr 7: load sees memory, not the new store
    drv(1, 1, 7, 32'h55);
    chk("t4_data", bus.ld_data, 32'h10);
    chk("t4_stall", bus.stall, 0);
    tick();
    drv(0, 0, 0, 0);
    chk("t4_memwr", bus.mem_wr, 1);
    chk("t4_addr", bus.mem_addr, 7);
    chk("t4_wdata", bus.mem_wdata, 32'h55);
    tick();
    chk("t4_mem7", mem[7], 32'h55);

    // reset with 3 pending stores discards them
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 20 + i, 32'hA0 + i);
      tick();
    end
    drv(0, 0, 0, 0);
    chk("t5_pending", bus.sb_empty, 0);
    rst = 1'b1;
    #1;
    chk("t5_rst_memwr", bus.mem_wr, 0);
    chk("t5_rst_empty", bus.sb_empty, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_empty", bus.sb_empty, 1);
    chk("t5_memwr", bus.mem_wr, 0);
    tick(); tick();
    for (int i = 0; i < 3; i++) chk($sformatf("t5_mem%0d", 20 + i), mem[20 + i], 0);

    // wrap-around: store/drain pairs to 0..9
    for (int i = 0; i < 10; i++) begin
      drv(1, 0, i, 32'h100 + i);
      chk($sformatf("t6_s%0d_stall", i), bus.stall, 0);
      if (i > 0) chk($sformatf("t6_s%0d_addr", i), bus.mem_addr, i - 1);
      tick();
    end
    drv(0, 0, 0, 0);
    chk("t6_last_addr", bus.mem_addr, 9);
    tick();
    chk("t6_empty", bus.sb_empty, 1);
    for (int i = 0; i < 10; i++) chk($sformatf("t6_mem%0d", i), mem[i], 32'h100 + i);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
